ethernet_tx_arbiter: RTL and testbench

//  Shares the single TEMAC transmit byte stream between the IP and ARP transmit sources.

---
 rtl/ethernet_tx_arbiter_if.sv | 13 +
 rtl/ethernet_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_ethernet_tx_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_tx_arbiter_if.sv
// Byte-stream handshake with destination-MAC sideband, shared by the IP, ARP and TEMAC TX links.
interface ethernet_tx_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;
  logic [47:0]           dest_mac;

  modport master (output tvalid, output tdata, output tlast, output dest_mac, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input dest_mac, output tready);
endinterface

// File: rtl/ethernet_tx_arbiter.sv
// Packet-level round-robin arbiter between IP and ARP TX sources onto the TEMAC TX stream.
// Prepends the Ethernet header and enforces a fixed inter-packet gap.
module ethernet_tx_arbiter #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned HEADER_BYTE_COUNT = 14,
  parameter int unsigned INTERPACKET_GAP   = 12,
  parameter logic [15:0] IP_ETHER_TYPE     = 16'h0800,
  parameter logic [15:0] ARP_ETHER_TYPE    = 16'h0806
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [47:0]                  local_mac_address,
  ethernet_tx_arbiter_if.slave         ip_tx,
  ethernet_tx_arbiter_if.slave         arp_tx,
  ethernet_tx_arbiter_if.master        temac_tx,
  output logic [1:0]                   active_grant,
  output logic                         tx_busy
);

  localparam int unsigned HDR_BITS = HEADER_BYTE_COUNT * DATA_WIDTH;
  localparam int unsigned IDX_W    = $clog2(HEADER_BYTE_COUNT);
  localparam int unsigned GAP_W    = $clog2(INTERPACKET_GAP + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HEADER_BYTE_COUNT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(INTERPACKET_GAP - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_arp_q, last_arp_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [HDR_BITS-1:0] hdr_q, hdr_d;
  logic                pick_arp;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_arp_q <= 1'b1;
      idx_q      <= '0;
      gap_q      <= '0;
      hdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_arp_q <= last_arp_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      hdr_q      <= hdr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_arp_d      = last_arp_q;
    idx_d           = idx_q;
    gap_d           = gap_q;
    hdr_d           = hdr_q;
    pick_arp        = 1'b0;
    temac_tx.tvalid = 1'b0;
    temac_tx.tdata  = '0;
    temac_tx.tlast  = 1'b0;
    ip_tx.tready    = 1'b0;
    arp_tx.tready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ip_tx.tvalid || arp_tx.tvalid) begin
          // On a tie, serve whichever source did not win last time
          pick_arp   = arp_tx.tvalid && (!ip_tx.tvalid || !last_arp_q);
          grant_d    = pick_arp ? 2'b10 : 2'b01;
          last_arp_d = pick_arp;
          hdr_d      = pick_arp ? {arp_tx.dest_mac, local_mac_address, ARP_ETHER_TYPE}
                                : {ip_tx.dest_mac, local_mac_address, IP_ETHER_TYPE};
          idx_d      = '0;
          state_d    = HEADER;
        end
      end
      HEADER: begin
        // Header is a left-shifting register; the top byte is always the one on the bus
        temac_tx.tvalid = 1'b1;
        temac_tx.tdata  = hdr_q[HDR_BITS-1 -: DATA_WIDTH];
        if (temac_tx.tready) begin
          hdr_d = hdr_q << DATA_WIDTH;
          if (idx_q == IDX_LAST) state_d = PAYLOAD;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      PAYLOAD: begin
        if (grant_q[1]) begin
          temac_tx.tvalid = arp_tx.tvalid;
          temac_tx.tdata  = arp_tx.tdata;
          temac_tx.tlast  = arp_tx.tlast;
          arp_tx.tready   = temac_tx.tready;
        end else begin
          temac_tx.tvalid = ip_tx.tvalid;
          temac_tx.tdata  = ip_tx.tdata;
          temac_tx.tlast  = ip_tx.tlast;
          ip_tx.tready    = temac_tx.tready;
        end
        if (temac_tx.tvalid && temac_tx.tready && temac_tx.tlast) begin
          state_d = GAP;
          gap_d   = '0;
          grant_d = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign temac_tx.dest_mac = '0;
  assign active_grant      = grant_q;
  assign tx_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Directed bench for ethernet_tx_arbiter: header insertion, round-robin, gap timing, flow control, reset.
module tb_ethernet_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] local_mac;
  logic [1:0]  active_grant;
  logic        tx_busy;

  ethernet_tx_arbiter_if #(.DATA_WIDTH(8)) ip_if ();
  ethernet_tx_arbiter_if #(.DATA_WIDTH(8)) arp_if ();
  ethernet_tx_arbiter_if #(.DATA_WIDTH(8)) temac_if ();

  always #5 clock = ~clock;

  ethernet_tx_arbiter #(
    .DATA_WIDTH(8), .HEADER_BYTE_COUNT(14), .INTERPACKET_GAP(12),
    .IP_ETHER_TYPE(16'h0800), .ARP_ETHER_TYPE(16'h0806)
  ) dut (
    .clock(clock), .reset(reset), .local_mac_address(local_mac),
    .ip_tx(ip_if.slave), .arp_tx(arp_if.slave), .temac_tx(temac_if.master),
    .active_grant(active_grant), .tx_busy(tx_busy)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0]  ip_pay[$], arp_pay[$], exp_q[$];
  bit          ip_en, arp_en, ip_rep, arp_rep, ip_drop, rdy_toggle;
  int          ip_idx, arp_idx;
  logic [47:0] ip_dest, arp_dest;
  logic [7:0]  cap_data[$];
  bit          cap_last[$];
  int          cap_cyc[$];
  logic [1:0]  cap_grant[$];
  int          cap_frames, ip_bad, arp_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample 1ns later, predict the coming posedge's handshakes
  task automatic cycle();
    @(negedge clock);
    cyc++;
    temac_if.tready = rdy_toggle ? ((cyc % 2) == 0) : 1'b1;
    ip_if.dest_mac  = ip_dest;
    ip_if.tvalid    = ip_en && !(ip_drop && (cyc % 5 == 3));
    ip_if.tdata     = ip_en ? ip_pay[ip_idx] : 8'h00;
    ip_if.tlast     = ip_en && (ip_idx == ip_pay.size() - 1);
    arp_if.dest_mac = arp_dest;
    arp_if.tvalid   = arp_en;
    arp_if.tdata    = arp_en ? arp_pay[arp_idx] : 8'h00;
    arp_if.tlast    = arp_en && (arp_idx == arp_pay.size() - 1);
    #1;
    if (temac_if.tvalid && temac_if.tready) begin
      cap_data.push_back(temac_if.tdata);
      cap_last.push_back(temac_if.tlast);
      cap_cyc.push_back(cyc);
      cap_grant.push_back(active_grant);
      if (temac_if.tlast) cap_frames++;
    end
    if (ip_if.tready && active_grant != 2'b01) ip_bad++;
    if (arp_if.tready && active_grant != 2'b10) arp_bad++;
    if (ip_if.tvalid && ip_if.tready) begin
      if (ip_if.tlast) begin ip_idx = 0; if (!ip_rep) ip_en = 0; end
      else ip_idx++;
    end
    if (arp_if.tvalid && arp_if.tready) begin
      if (arp_if.tlast) begin arp_idx = 0; if (!arp_rep) arp_en = 0; end
      else arp_idx++;
    end
  endtask

  task automatic clear_caps();
    cap_data.delete(); cap_last.delete(); cap_cyc.delete(); cap_grant.delete();
    cap_frames = 0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int k = 0;
    while (cap_frames < n && k < budget) begin cycle(); k++; end
    check(tag, cap_frames, n);
  endtask

  task automatic build_exp(input logic [47:0] dest, input logic [15:0] etype, input logic [7:0] pay[$]);
    logic [111:0] h;
    h = {dest, local_mac, etype};
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(h[111 - 8*i -: 8]);
    foreach (pay[i]) exp_q.push_back(pay[i]);
  endtask

  task automatic cmp_frame(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), cap_data[base+i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), cap_last[base+i], (i == exp_q.size() - 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, temac_if.tvalid, 1'b0);
    check({tag, "_tdata"},  temac_if.tdata, 8'h00);
    check({tag, "_tlast"},  temac_if.tlast, 1'b0);
    check({tag, "_grant"},  active_grant, 2'b00);
    check({tag, "_busy"},   tx_busy, 1'b0);
    check({tag, "_ipr"},    ip_if.tready, 1'b0);
    check({tag, "_arpr"},   arp_if.tready, 1'b0);
  endtask

  initial begin
    int start;
    int k;
    reset = 1'b1; local_mac = 48'h112233445566;
    ip_en = 0; arp_en = 0; ip_rep = 0; arp_rep = 0; ip_drop = 0; rdy_toggle = 0;
    ip_idx = 0; arp_idx = 0; ip_bad = 0; arp_bad = 0;
    ip_dest = 48'hF071AD9025B4; arp_dest = 48'hFFFFFFFFFFFF;
    temac_if.tready = 1'b1;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // IP only, 4-byte payload
    ip_pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    ip_en = 1; clear_caps();
    start = cyc + 1;
    wait_frames("t1_done", 1, 100);
    check("t1_len", cap_data.size(), 18);
    build_exp(48'hF071AD9025B4, 16'h0800, ip_pay);
    cmp_frame("t1", 0);
    check("t1_latency", cap_cyc[0] - start, 1);
    check("t1_span", cap_cyc[17] - cap_cyc[0], 17);
    check("t1_grant", cap_grant[0], 2'b01);
    cycle();
    check("t1_gap_grant", active_grant, 2'b00);
    check("t1_gap_busy", tx_busy, 1'b1);
    check("t1_gap_tvalid", temac_if.tvalid, 1'b0);
    repeat (15) cycle();
    check("t1_idle_busy", tx_busy, 1'b0);

    // Both sources valid from reset: IP, ARP, IP with exact gap
    do_reset();
    ip_pay.delete(); arp_pay.delete();
    for (int i = 0; i < 28; i++) begin ip_pay.push_back(8'(8'h10 + i)); arp_pay.push_back(8'(8'h80 + i)); end
    ip_en = 1; arp_en = 1; ip_rep = 1; arp_rep = 1; clear_caps();
    wait_frames("t2_done", 3, 400);
    ip_en = 0; arp_en = 0; ip_rep = 0; arp_rep = 0; ip_idx = 0; arp_idx = 0;
    check("t2_grant0", cap_grant[0], 2'b01);
    check("t2_grant1", cap_grant[42], 2'b10);
    check("t2_grant2", cap_grant[84], 2'b01);
    build_exp(48'hF071AD9025B4, 16'h0800, ip_pay);  cmp_frame("t2_ip0", 0);
    build_exp(48'hFFFFFFFFFFFF, 16'h0806, arp_pay); cmp_frame("t2_arp", 42);
    build_exp(48'hF071AD9025B4, 16'h0800, ip_pay);  cmp_frame("t2_ip1", 84);
    check("t2_gap0", cap_cyc[42] - cap_cyc[41], 14);
    check("t2_gap1", cap_cyc[84] - cap_cyc[83], 14);
    repeat (20) cycle();

    // Toggling TEMAC ready, source valid drops, dest MAC changed after grant
    ip_pay.delete();
    for (int i = 0; i < 60; i++) ip_pay.push_back(8'(i * 7 + 3));
    build_exp(48'hF071AD9025B4, 16'h0800, ip_pay);
    rdy_toggle = 1; ip_drop = 1; ip_en = 1; clear_caps();
    k = 0;
    while (cap_data.size() == 0 && k < 50) begin cycle(); k++; end
    ip_dest = 48'h000000000000;
    wait_frames("t3_done", 1, 600);
    check("t3_len", cap_data.size(), 74);
    cmp_frame("t3", 0);
    rdy_toggle = 0; ip_drop = 0; ip_dest = 48'hF071AD9025B4;
    repeat (20) cycle();

    // ARP request arriving mid IP payload waits for the gap
    ip_pay.delete(); arp_pay.delete();
    for (int i = 0; i < 20; i++) ip_pay.push_back(8'(8'h40 + i));
    for (int i = 0; i < 28; i++) arp_pay.push_back(8'(8'hC0 + i));
    ip_en = 1; ip_bad = 0; arp_bad = 0; clear_caps();
    k = 0;
    while (cap_data.size() < 16 && k < 50) begin cycle(); k++; end
    arp_en = 1;
    wait_frames("t4_done", 2, 300);
    check("t4_grant_ip", cap_grant[0], 2'b01);
    check("t4_grant_arp", cap_grant[34], 2'b10);
    check("t4_span_ip", cap_cyc[33] - cap_cyc[0], 33);
    check("t4_gap", cap_cyc[34] - cap_cyc[33], 14);
    check("t4_arp_ready_leak", arp_bad, 0);
    check("t4_ip_ready_leak", ip_bad, 0);
    build_exp(48'hFFFFFFFFFFFF, 16'h0806, arp_pay); cmp_frame("t4_arp", 34);
    repeat (20) cycle();

    // Reset mid payload abandons frame; IP still wins the next tie
    ip_pay.delete();
    for (int i = 0; i < 30; i++) ip_pay.push_back(8'(8'h20 + i));
    ip_en = 1; clear_caps();
    k = 0;
    while (cap_data.size() < 19 && k < 100) begin cycle(); k++; end
    check("t5_reached", cap_data.size(), 19);
    reset = 1'b1;
    cycle();
    check_idle_outputs("t5_reset");
    ip_idx = 0; arp_idx = 0; arp_en = 1; ip_en = 1; clear_caps();
    cycle();
    reset = 1'b0;
    wait_frames("t5_done", 1, 200);
    check("t5_first_byte", cap_data[0], 8'hF0);
    check("t5_grant", cap_grant[0], 2'b01);
    build_exp(48'hF071AD9025B4, 16'h0800, ip_pay); cmp_frame("t5", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
